// File: rtl/div_scheduler_pkg.sv
// Shared types and constants for the divider scheduler.
// Imported by the scheduler, its divider and its interface.
package div_scheduler_pkg;

  localparam int DIV_W = 16;
  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 16'hFFFF;
  localparam int DIV_LATENCY = 22;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    D_IDLE   = 3'd0,
    D_INIT   = 3'd1,
    D_DIV    = 3'd2,
    D_CHECK  = 3'd3,
    D_FINISH = 3'd4
  } dstate_t;

endpackage

// File: rtl/div_scheduler_if.sv
// Request/response bundle between execute-stage clients
// and the shared divider scheduler.
interface div_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import div_scheduler_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [DIV_W*NUM_REQ-1:0] req_dividend;
  logic [DIV_W*NUM_REQ-1:0] req_divisor;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [DIV_W-1:0]         resp_quotient;
  logic [DIV_W-1:0]         resp_remainder;
  logic                     resp_dbz;
  logic                     busy;

  modport master (
    output req_valid, req_dividend, req_divisor,
    input  req_ready, resp_valid, resp_id,
    input  resp_quotient, resp_remainder,
    input  resp_dbz, busy
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    output req_ready, resp_valid, resp_id,
    output resp_quotient, resp_remainder,
    output resp_dbz, busy
  );

endinterface

// File: rtl/div_scheduler_div.sv
// Iterative 16/16 unsigned restoring divider, one bit
// per cycle, with a start pulse and a sticky done level.
module restoring_division
  import div_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             done
);

  dstate_t          st, st_n;
  logic [DIV_W-1:0] rem, quo;
  logic [4:0]       cnt;
  logic [DIV_W:0]   shifted, diff;

  // rem < divisor holds, so a set borrow bit means restore
  assign shifted = {rem, quo[DIV_W-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    st_n = st;
    unique case (st)
      D_IDLE:   if (start) st_n = D_INIT;
      D_INIT:   st_n = D_DIV;
      D_DIV:    if (cnt == 5'(DIV_W-1)) st_n = D_CHECK;
      D_CHECK:  st_n = (cnt == 5'(DIV_W)) ? D_FINISH : D_DIV;
      D_FINISH: st_n = D_IDLE;
      default:  st_n = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= D_IDLE;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      st <= st_n;
      unique case (st)
        D_IDLE: if (start) done <= 1'b0;
        D_INIT: begin
          rem <= '0;
          quo <= dividend;
          cnt <= '0;
        end
        D_DIV: begin
          cnt <= cnt + 5'd1;
          if (!diff[DIV_W]) begin
            rem <= diff[DIV_W-1:0];
            quo <= {quo[DIV_W-2:0], 1'b1};
          end else begin
            rem <= shifted[DIV_W-1:0];
            quo <= {quo[DIV_W-2:0], 1'b0};
          end
        end
        D_FINISH: begin
          quotient  <= quo;
          remainder <= rem;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin arbiter sharing one restoring divider among
// NUM_REQ requesters; divide-by-zero bypasses the divider.
module div_scheduler
  import div_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic            clk,
  input logic            reset_n,
  div_scheduler_if.slave bus
);

  function automatic logic [ID_W:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [ID_W-1:0]    ptr
  );
    logic [ID_W:0]   r;
    logic [ID_W-1:0] k;
    int              idx;
    r = '0;
    // walk downward so the closest valid index wins last
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      k = ID_W'(idx);
      if (v[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  state_t           state, nxt;
  logic [ID_W-1:0]  rr_ptr, op_id, gnt_id;
  logic [ID_W:0]    pick;
  logic             gnt_ok, div_start, div_done;
  logic [DIV_W-1:0] op_a, op_b, sel_a, sel_b;
  logic [DIV_W-1:0] div_q, div_r;
  logic [NUM_REQ-1:0] ready;

  assign pick   = rr_pick(bus.req_valid, rr_ptr);
  assign gnt_ok = pick[ID_W];
  assign gnt_id = pick[ID_W-1:0];
  assign sel_a  = bus.req_dividend[int'(gnt_id)*DIV_W +: DIV_W];
  assign sel_b  = bus.req_divisor[int'(gnt_id)*DIV_W +: DIV_W];

  always_comb begin
    ready = '0;
    if (state == S_IDLE && gnt_ok) ready[gnt_id] = 1'b1;
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.busy       = (state != S_IDLE);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (gnt_ok) nxt = (sel_b == '0) ? S_RESP : S_ISSUE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  if (div_done) nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      rr_ptr             <= '0;
      op_a               <= '0;
      op_b               <= '0;
      op_id              <= '0;
      div_start          <= 1'b0;
      bus.resp_id        <= '0;
      bus.resp_quotient  <= '0;
      bus.resp_remainder <= '0;
      bus.resp_dbz       <= 1'b0;
    end else begin
      state     <= nxt;
      div_start <= (nxt == S_ISSUE);
      unique case (state)
        S_IDLE: if (gnt_ok) begin
          op_a  <= sel_a;
          op_b  <= sel_b;
          op_id <= gnt_id;
          if (sel_b == '0) begin
            bus.resp_id        <= gnt_id;
            bus.resp_quotient  <= DBZ_QUOTIENT;
            bus.resp_remainder <= sel_a;
            bus.resp_dbz       <= 1'b1;
          end
        end
        S_WAIT: if (div_done) begin
          bus.resp_id        <= op_id;
          bus.resp_quotient  <= div_q;
          bus.resp_remainder <= div_r;
          bus.resp_dbz       <= 1'b0;
        end
        S_RESP:
          rr_ptr <= (op_id == ID_W'(NUM_REQ-1)) ?
                    '0 : op_id + 1'b1;
        default: ;
      endcase
    end
  end

  restoring_division u_div (
    .clk       (clk),
    .rst       (~reset_n),
    .start     (div_start),
    .dividend  (op_a),
    .divisor   (op_b),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler: latency, operands,
// divide-by-zero, round-robin order, reset abort.
module tb_div_scheduler;
  import div_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  div_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus();

  div_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } rsp_t;

  rsp_t rsp[$];
  int   gid[$];
  int   gcyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   viol = 0;
  int   busy_cnt = 0;
  logic hold = 1'b0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] hs;
    rsp_t e;
    @(negedge clk);
    hs = bus.req_ready & bus.req_valid;
    if (bus.req_ready != 4'd0 && bus.busy) viol++;
    if ($countones(bus.req_ready) > 1) viol++;
    for (int i = 0; i < 4; i++)
      if (hs[i]) begin
        gid.push_back(i);
        gcyc.push_back(cyc);
      end
    if (bus.resp_valid) begin
      e.cyc = cyc;
      e.id  = int'(bus.resp_id);
      e.q   = bus.resp_quotient;
      e.r   = bus.resp_remainder;
      e.dbz = bus.resp_dbz;
      rsp.push_back(e);
    end
    if (bus.busy) busy_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (!hold) bus.req_valid = bus.req_valid & ~hs;
  endtask

  task automatic clear();
    rsp.delete();
    gid.delete();
    gcyc.delete();
  endtask

  task automatic set_req(int i, logic [15:0] a,
                         logic [15:0] b);
    bus.req_dividend[16*i +: 16] = a;
    bus.req_divisor[16*i +: 16]  = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_resp(string tag, int n, int budget);
    int k = 0;
    while (rsp.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_count"}, rsp.size(), n);
  endtask

  task automatic chk_reset(string p);
    chk({p, "_ready"}, bus.req_ready, 0);
    chk({p, "_valid"}, bus.resp_valid, 0);
    chk({p, "_id"}, bus.resp_id, 0);
    chk({p, "_q"}, bus.resp_quotient, 0);
    chk({p, "_r"}, bus.resp_remainder, 0);
    chk({p, "_dbz"}, bus.resp_dbz, 0);
    chk({p, "_busy"}, bus.busy, 0);
  endtask

  task automatic chk_one(string tag, int id,
                         logic [15:0] q, logic [15:0] r,
                         logic dbz, int lat);
    if (rsp.size() >= 1 && gcyc.size() >= 1) begin
      chk({tag, "_lat"}, rsp[0].cyc - gcyc[0], lat);
      chk({tag, "_id"}, rsp[0].id, id);
      chk({tag, "_q"}, rsp[0].q, q);
      chk({tag, "_r"}, rsp[0].r, r);
      chk({tag, "_dbz"}, rsp[0].dbz, dbz);
    end
  endtask

  int          exp_id[5] = '{0, 1, 2, 3, 0};
  logic [15:0] fa[4] = '{16'd1000, 16'd999, 16'd65535, 16'd12345};
  logic [15:0] fb[4] = '{16'd10, 16'd4, 16'd256, 16'd123};
  logic [15:0] fq[4] = '{16'd100, 16'd249, 16'd255, 16'd100};
  logic [15:0] fr[4] = '{16'd0, 16'd3, 16'd255, 16'd45};

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    repeat (3) tick();
    chk_reset("rst");
    reset_n = 1'b1;
    tick();

    clear();
    set_req(0, 16'd100, 16'd7);
    wait_resp("single", 1, 40);
    chk_one("single", 0, 16'd14, 16'd2, 1'b0, DIV_LATENCY);
    tick();
    chk("hold_q", bus.resp_quotient, 16'd14);
    chk("hold_valid", bus.resp_valid, 0);

    clear();
    set_req(1, 16'hFFFF, 16'd1);
    wait_resp("max", 1, 40);
    chk_one("max", 1, 16'hFFFF, 16'd0, 1'b0, DIV_LATENCY);

    clear();
    set_req(3, 16'd5, 16'd9);
    wait_resp("small", 1, 40);
    chk_one("small", 3, 16'd0, 16'd5, 1'b0, DIV_LATENCY);

    clear();
    busy_cnt = 0;
    set_req(2, 16'd1234, 16'd0);
    wait_resp("dbz", 1, 10);
    tick();
    chk_one("dbz", 2, 16'hFFFF, 16'd1234, 1'b1, 1);
    chk("dbz_busy", busy_cnt, 1);

    clear();
    set_req(1, 16'd7, 16'd0);
    wait_resp("ptr_setup", 1, 10);
    clear();
    set_req(1, 16'd11, 16'd0);
    set_req(3, 16'd33, 16'd0);
    wait_resp("ptr", 2, 20);
    if (gid.size() >= 2 && rsp.size() >= 2) begin
      chk("ptr_first", gid[0], 3);
      chk("ptr_second", gid[1], 1);
      chk("ptr_r0", rsp[0].r, 16'd33);
      chk("ptr_r1", rsp[1].r, 16'd11);
    end

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clear();
    for (int i = 0; i < 4; i++) set_req(i, fa[i], fb[i]);
    wait_resp("fair", 4, 150);
    if (gid.size() >= 4 && rsp.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fair_gnt%0d", i), gid[i], i);
        chk($sformatf("fair_id%0d", i), rsp[i].id, i);
        chk($sformatf("fair_q%0d", i), rsp[i].q, fq[i]);
        chk($sformatf("fair_r%0d", i), rsp[i].r, fr[i]);
      end
    end

    clear();
    viol = 0;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, fa[i], fb[i]);
    wait_resp("b2b", 5, 150);
    if (gid.size() >= 1 && rsp.size() >= 5) begin
      chk("b2b_first", gid[0], 0);
      for (int i = 0; i < 5; i++)
        chk($sformatf("b2b_id%0d", i), rsp[i].id, exp_id[i]);
      for (int i = 1; i < 5; i++)
        chk($sformatf("b2b_gap%0d", i),
            rsp[i].cyc - rsp[i-1].cyc, DIV_LATENCY + 1);
    end
    hold = 1'b0;
    begin
      int k = 0;
      while ((bus.req_valid != 4'd0 || bus.busy) && k < 300) begin
        tick();
        k++;
      end
    end
    chk("drain", bus.req_valid, 0);
    chk("ready_outside_idle", viol, 0);

    clear();
    set_req(0, 16'd200, 16'd3);
    begin
      int k = 0;
      while (gcyc.size() < 1 && k < 10) begin
        tick();
        k++;
      end
    end
    chk("mid_gnt", gcyc.size(), 1);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk_reset("mid");
    repeat (3) tick();
    chk("mid_no_resp", rsp.size(), 0);
    reset_n = 1'b1;
    clear();
    set_req(1, 16'd200, 16'd3);
    wait_resp("after", 1, 40);
    chk_one("after", 1, 16'd66, 16'd2, 1'b0, DIV_LATENCY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
